// File: rtl/failure_responder.sv
// Latches the first stop/UCF failure as a time-stamped stop request to the host; counts later events.
// Latency: capture, fail_req and fail_count update on the same edge that samples the rising failure.
// Backpressure: four-phase req/ack; events arriving before the handshake completes only count and set overflow.
module failure_responder #(
    parameter int CNT_W    = 32,
    parameter int CNT8_MAX = 255
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enable,
    input  logic             stop_in,
    input  logic             ucf_in,
    input  logic             fail_ack,
    output logic             fail_req,
    output logic [1:0]       fail_cause,
    output logic [CNT_W-1:0] fail_time,
    output logic [7:0]       fail_count,
    output logic             overflow
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PENDING = 2'd1,
        ACKED   = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic             prev;
    logic [CNT_W-1:0] cyc_cnt;
    logic             fail_any;
    logic             fail_evt;
    logic             capture;
    logic             ovf_set;
    logic             ovf_clr;

    assign fail_any = stop_in | ucf_in;
    assign fail_evt = enable & fail_any & ~prev;

    // An event on the ACKED->IDLE edge still belongs to ACKED: overflow wins over the clear.
    always_comb begin
        state_nxt = state;
        capture   = 1'b0;
        ovf_set   = 1'b0;
        ovf_clr   = 1'b0;
        case (state)
            IDLE: begin
                if (fail_evt) begin
                    capture   = 1'b1;
                    state_nxt = PENDING;
                end
            end
            PENDING: begin
                ovf_set = fail_evt;
                if (fail_ack) begin
                    state_nxt = ACKED;
                end
            end
            ACKED: begin
                ovf_set = fail_evt;
                if (!fail_ack) begin
                    state_nxt = IDLE;
                    ovf_clr   = 1'b1;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            prev       <= 1'b0;
            cyc_cnt    <= '0;
            fail_req   <= 1'b0;
            fail_cause <= 2'b00;
            fail_time  <= '0;
            fail_count <= 8'd0;
            overflow   <= 1'b0;
        end else begin
            state    <= state_nxt;
            prev     <= fail_any;
            fail_req <= (state_nxt == PENDING);
            if (enable) begin
                cyc_cnt <= cyc_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
            end
            if (capture) begin
                fail_cause <= {ucf_in, stop_in};
                fail_time  <= cyc_cnt;
            end
            if (fail_evt && (fail_count != 8'(CNT8_MAX))) begin
                fail_count <= fail_count + 8'd1;
            end
            if (ovf_set) begin
                overflow <= 1'b1;
            end else if (ovf_clr) begin
                overflow <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_failure_responder.sv
// Scoreboard bench for failure_responder with a 4-bit cycle counter so wrap is reachable.
module tb_failure_responder;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       enable;
    logic       stop_in;
    logic       ucf_in;
    logic       fail_ack;
    logic       fail_req;
    logic [1:0] fail_cause;
    logic [3:0] fail_time;
    logic [7:0] fail_count;
    logic       overflow;

    int checks   = 0;
    int failures = 0;

    typedef struct packed {
        logic       req;
        logic [1:0] cause;
        logic [3:0] tm;
        logic [7:0] cnt;
        logic       ovf;
    } out_t;

    typedef struct {
        string name;
        out_t  v;
    } exp_t;

    exp_t sb[$];

    failure_responder #(.CNT_W(4), .CNT8_MAX(255)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .enable     (enable),
        .stop_in    (stop_in),
        .ucf_in     (ucf_in),
        .fail_ack   (fail_ack),
        .fail_req   (fail_req),
        .fail_cause (fail_cause),
        .fail_time  (fail_time),
        .fail_count (fail_count),
        .overflow   (overflow)
    );

    always #5 clk = ~clk;

    function automatic out_t mk(logic r, logic [1:0] c, logic [3:0] t, logic [7:0] n, logic o);
        return {r, c, t, n, o};
    endfunction

    function automatic out_t obs();
        return {fail_req, fail_cause, fail_time, fail_count, overflow};
    endfunction

    function automatic string fmt(out_t o);
        return $sformatf("req=%0d cause=%b time=%0d cnt=%0d ovf=%0d", o.req, o.cause, o.tm, o.cnt, o.ovf);
    endfunction

    task automatic push(string n, out_t v);
        exp_t x;
        x.name = n;
        x.v    = v;
        sb.push_back(x);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        stop_in  = 1'b0;
        ucf_in   = 1'b0;
        fail_ack = 1'b0;
        rst_n    = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        exp_t e;
        rst_n    = 1'b0;
        enable   = 1'b0;
        stop_in  = 1'b0;
        ucf_in   = 1'b0;
        fail_ack = 1'b0;
        push("reset_state", mk(0, 2'b00, 0, 0, 0));
        tick();
        e = sb.pop_front(); checks++;
        if (obs() !== e.v) begin failures++; $display("FAIL %s: got %s, expected %s", e.name, fmt(obs()), fmt(e.v)); end
    endtask

    task automatic test_capture();
        exp_t e;
        do_reset();
        enable = 1'b1;
        push("cap_quiet", mk(0, 2'b00, 0, 0, 0));
        repeat (10) tick();
        e = sb.pop_front(); checks++;
        if (obs() !== e.v) begin failures++; $display("FAIL %s: got %s, expected %s", e.name, fmt(obs()), fmt(e.v)); end
        stop_in = 1'b1;
        push("cap_event", mk(1, 2'b01, 10, 1, 0));
        tick();
        e = sb.pop_front(); checks++;
        if (obs() !== e.v) begin failures++; $display("FAIL %s: got %s, expected %s", e.name, fmt(obs()), fmt(e.v)); end
        stop_in  = 1'b0;
        fail_ack = 1'b1;
        push("cap_acked", mk(0, 2'b01, 10, 1, 0));
        tick();
        e = sb.pop_front(); checks++;
        if (obs() !== e.v) begin failures++; $display("FAIL %s: got %s, expected %s", e.name, fmt(obs()), fmt(e.v)); end
        fail_ack = 1'b0;
        tick();
    endtask

    task automatic test_level();
        exp_t e;
        do_reset();
        enable  = 1'b1;
        stop_in = 1'b1;
        ucf_in  = 1'b1;
        push("lvl_first_edge", mk(1, 2'b11, 0, 1, 0));
        tick();
        e = sb.pop_front(); checks++;
        if (obs() !== e.v) begin failures++; $display("FAIL %s: got %s, expected %s", e.name, fmt(obs()), fmt(e.v)); end
        push("lvl_held", mk(1, 2'b11, 0, 1, 0));
        repeat (19) tick();
        e = sb.pop_front(); checks++;
        if (obs() !== e.v) begin failures++; $display("FAIL %s: got %s, expected %s", e.name, fmt(obs()), fmt(e.v)); end
        stop_in = 1'b0;
        ucf_in  = 1'b0;
    endtask

    task automatic test_overflow();
        exp_t e;
        do_reset();
        enable  = 1'b1;
        stop_in = 1'b1; tick();
        stop_in = 1'b0; tick();
        ucf_in  = 1'b1; tick();
        ucf_in  = 1'b0; tick();
        ucf_in  = 1'b1;
        push("ovf_two_more", mk(1, 2'b01, 0, 3, 1));
        tick();
        e = sb.pop_front(); checks++;
        if (obs() !== e.v) begin failures++; $display("FAIL %s: got %s, expected %s", e.name, fmt(obs()), fmt(e.v)); end
        ucf_in   = 1'b0;
        fail_ack = 1'b1;
        push("ovf_acked", mk(0, 2'b01, 0, 3, 1));
        tick();
        e = sb.pop_front(); checks++;
        if (obs() !== e.v) begin failures++; $display("FAIL %s: got %s, expected %s", e.name, fmt(obs()), fmt(e.v)); end
        fail_ack = 1'b0;
        push("ovf_cleared", mk(0, 2'b01, 0, 3, 0));
        tick();
        e = sb.pop_front(); checks++;
        if (obs() !== e.v) begin failures++; $display("FAIL %s: got %s, expected %s", e.name, fmt(obs()), fmt(e.v)); end
        push("ovf_req_stays_low", mk(0, 2'b01, 0, 3, 0));
        tick();
        e = sb.pop_front(); checks++;
        if (obs() !== e.v) begin failures++; $display("FAIL %s: got %s, expected %s", e.name, fmt(obs()), fmt(e.v)); end
    endtask

    task automatic test_handshake();
        exp_t e;
        do_reset();
        enable   = 1'b1;
        fail_ack = 1'b1;
        push("hs_ack_in_idle", mk(0, 2'b00, 0, 0, 0));
        tick();
        e = sb.pop_front(); checks++;
        if (obs() !== e.v) begin failures++; $display("FAIL %s: got %s, expected %s", e.name, fmt(obs()), fmt(e.v)); end
        fail_ack = 1'b0;
        tick();
        stop_in = 1'b1;
        push("hs_capture", mk(1, 2'b01, 2, 1, 0));
        tick();
        e = sb.pop_front(); checks++;
        if (obs() !== e.v) begin failures++; $display("FAIL %s: got %s, expected %s", e.name, fmt(obs()), fmt(e.v)); end
        stop_in  = 1'b0;
        fail_ack = 1'b1;
        tick();
        fail_ack = 1'b0;
        ucf_in   = 1'b1;
        push("hs_evt_on_release", mk(0, 2'b01, 2, 2, 1));
        tick();
        e = sb.pop_front(); checks++;
        if (obs() !== e.v) begin failures++; $display("FAIL %s: got %s, expected %s", e.name, fmt(obs()), fmt(e.v)); end
        ucf_in = 1'b0;
        tick();
        ucf_in = 1'b1;
        push("hs_next_capture", mk(1, 2'b10, 6, 3, 1));
        tick();
        e = sb.pop_front(); checks++;
        if (obs() !== e.v) begin failures++; $display("FAIL %s: got %s, expected %s", e.name, fmt(obs()), fmt(e.v)); end
        ucf_in = 1'b0;
    endtask

    task automatic test_wrap_enable();
        exp_t e;
        do_reset();
        enable = 1'b1;
        repeat (17) tick();
        stop_in = 1'b1;
        push("wrap_time", mk(1, 2'b01, 1, 1, 0));
        tick();
        e = sb.pop_front(); checks++;
        if (obs() !== e.v) begin failures++; $display("FAIL %s: got %s, expected %s", e.name, fmt(obs()), fmt(e.v)); end
        stop_in  = 1'b0;
        fail_ack = 1'b1; tick();
        fail_ack = 1'b0; tick();
        enable  = 1'b0;
        stop_in = 1'b1;
        push("dis_no_event", mk(0, 2'b01, 1, 1, 0));
        tick();
        e = sb.pop_front(); checks++;
        if (obs() !== e.v) begin failures++; $display("FAIL %s: got %s, expected %s", e.name, fmt(obs()), fmt(e.v)); end
        stop_in = 1'b0;
        repeat (3) tick();
        enable  = 1'b1;
        stop_in = 1'b1;
        push("dis_frozen_cnt", mk(1, 2'b01, 4, 2, 0));
        tick();
        e = sb.pop_front(); checks++;
        if (obs() !== e.v) begin failures++; $display("FAIL %s: got %s, expected %s", e.name, fmt(obs()), fmt(e.v)); end
        stop_in  = 1'b0;
        enable   = 1'b0;
        fail_ack = 1'b1;
        push("dis_ack_advances", mk(0, 2'b01, 4, 2, 0));
        tick();
        e = sb.pop_front(); checks++;
        if (obs() !== e.v) begin failures++; $display("FAIL %s: got %s, expected %s", e.name, fmt(obs()), fmt(e.v)); end
        fail_ack = 1'b0;
        tick();
        enable  = 1'b1;
        stop_in = 1'b1;
        push("dis_back_to_idle", mk(1, 2'b01, 5, 3, 0));
        tick();
        e = sb.pop_front(); checks++;
        if (obs() !== e.v) begin failures++; $display("FAIL %s: got %s, expected %s", e.name, fmt(obs()), fmt(e.v)); end
        stop_in = 1'b0;
    endtask

    task automatic test_saturate();
        exp_t e;
        do_reset();
        enable = 1'b1;
        push("sat_count", mk(1, 2'b01, 0, 255, 1));
        repeat (260) begin
            stop_in = 1'b1; tick();
            stop_in = 1'b0; tick();
        end
        e = sb.pop_front(); checks++;
        if (obs() !== e.v) begin failures++; $display("FAIL %s: got %s, expected %s", e.name, fmt(obs()), fmt(e.v)); end
    endtask

    task automatic test_reset_mid();
        exp_t e;
        do_reset();
        enable = 1'b1;
        push("mid_pending", mk(1, 2'b01, 0, 5, 1));
        repeat (5) begin
            stop_in = 1'b1; tick();
            stop_in = 1'b0; tick();
        end
        e = sb.pop_front(); checks++;
        if (obs() !== e.v) begin failures++; $display("FAIL %s: got %s, expected %s", e.name, fmt(obs()), fmt(e.v)); end
        #2;
        rst_n = 1'b0;
        push("mid_async_clear", mk(0, 2'b00, 0, 0, 0));
        #1;
        e = sb.pop_front(); checks++;
        if (obs() !== e.v) begin failures++; $display("FAIL %s: got %s, expected %s", e.name, fmt(obs()), fmt(e.v)); end
        tick();
        rst_n = 1'b1;
    endtask

    initial begin
        test_reset();
        test_capture();
        test_level();
        test_overflow();
        test_handshake();
        test_wrap_enable();
        test_saturate();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
